// File: rtl/sample_byte_serializer_if.sv
// Bus bundle for sample_byte_serializer: word-write side, FIFO status and
// the byte-stream valid/ready handshake.
interface sample_byte_serializer_if #(
   parameter int FIFO_DEPTH = 4
) ();
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [15:0]      word_in;
   logic             word_wr_en;
   logic             fifo_full;
   logic [LVL_W-1:0] fifo_level;
   logic             overflow;
   logic             clear_overflow;
   logic [7:0]       byte_out;
   logic             byte_valid;
   logic             byte_ready;
   logic             busy;

   modport slave (
      input  word_in, word_wr_en, clear_overflow, byte_ready,
      output fifo_full, fifo_level, overflow, byte_out, byte_valid, busy
   );

   modport master (
      output word_in, word_wr_en, clear_overflow, byte_ready,
      input  fifo_full, fifo_level, overflow, byte_out, byte_valid, busy
   );
endinterface

// File: rtl/sample_byte_serializer.sv
// Buffers 16-bit words in a small FIFO and streams each one out as two bytes,
// MSB first, over a valid/ready byte handshake with an optional inter-word gap.
module sample_byte_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   sample_byte_serializer_if.slave  io_bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {S_IDLE, S_MSB, S_LSB, S_GAP} state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wptr, r_rptr;
   logic [LVL_W-1:0]      r_level, w_level_nxt;
   logic                  r_full, r_overflow, r_busy;
   logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [7:0]            r_byte, w_byte_nxt;
   logic                  r_valid, w_valid_nxt;
   logic [7:0]            r_gap, w_gap_nxt;
   logic                  w_wr_acc, w_pop;

   // Full is the registered pre-edge flag, so a same-cycle pop never rescues a write.
   assign w_wr_acc    = io_bus.word_wr_en & ~r_full;
   assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
   assign w_level_nxt = r_level + LVL_W'(w_wr_acc) - LVL_W'(w_pop);

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wptr] <= io_bus.word_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_pop)    r_rptr <= r_rptr + 1'b1;
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
         if (io_bus.word_wr_en && r_full) r_overflow <= 1'b1;
         else if (io_bus.clear_overflow)  r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
         r_gap   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_byte  <= w_byte_nxt;
         r_valid <= w_valid_nxt;
         r_gap   <= w_gap_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_byte_nxt  = r_byte;
      w_valid_nxt = r_valid;
      w_gap_nxt   = r_gap;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_shreg_nxt = r_mem[r_rptr];
               w_byte_nxt  = r_mem[r_rptr][DATA_WIDTH-1 -: 8];
               w_valid_nxt = 1'b1;
               w_state_nxt = S_MSB;
            end
         end
         S_MSB: begin
            if (io_bus.byte_ready) begin
               w_byte_nxt  = r_shreg[7:0];
               w_state_nxt = S_LSB;
            end
         end
         S_LSB: begin
            if (io_bus.byte_ready) begin
               w_valid_nxt = 1'b0;
               w_byte_nxt  = '0;
               if (GAP_CYCLES > 0) begin
                  w_gap_nxt   = GAP_LOAD;
                  w_state_nxt = S_GAP;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_gap == 8'd0) w_state_nxt = S_IDLE;
            else               w_gap_nxt   = r_gap - 8'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign io_bus.fifo_full  = r_full;
   assign io_bus.fifo_level = r_level;
   assign io_bus.overflow   = r_overflow;
   assign io_bus.byte_out   = r_byte;
   assign io_bus.byte_valid = r_valid;
   assign io_bus.busy       = r_busy;
endmodule

// File: tb/tb_sample_byte_serializer.sv
// Directed bench for sample_byte_serializer: one instance without gap, one
// with GAP_CYCLES = 3, byte streams captured on every valid/ready transfer.
module tb_sample_byte_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   logic [7:0] qa[$];
   int         ca[$];
   logic [7:0] qb[$];
   int         cb[$];
   logic [15:0] exp_w [3];

   sample_byte_serializer_if #(.FIFO_DEPTH(4)) ifa ();
   sample_byte_serializer_if #(.FIFO_DEPTH(4)) ifb ();

   sample_byte_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .io_bus(ifa.slave)
   );
   sample_byte_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(3)) u_gap (
      .clk(clk), .rst_n(rst_n), .io_bus(ifb.slave)
   );

   always #5 clk = ~clk;

   // Record every accepted byte with the edge it was accepted on.
   always @(posedge clk) begin
      if (ifa.byte_valid && ifa.byte_ready) begin
         qa.push_back(ifa.byte_out);
         ca.push_back(cyc);
      end
      if (ifb.byte_valid && ifb.byte_ready) begin
         qb.push_back(ifb.byte_out);
         cb.push_back(cyc);
      end
      cyc = cyc + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      ifa.word_in = '0; ifa.word_wr_en = 0; ifa.clear_overflow = 0; ifa.byte_ready = 1;
      ifb.word_in = '0; ifb.word_wr_en = 0; ifb.clear_overflow = 0; ifb.byte_ready = 1;
      repeat (3) tick();
      check("rst_valid", 32'(ifa.byte_valid), 0);
      check("rst_byte", 32'(ifa.byte_out), 0);
      check("rst_level", 32'(ifa.fifo_level), 0);
      check("rst_full", 32'(ifa.fifo_full), 0);
      check("rst_ovf", 32'(ifa.overflow), 0);
      check("rst_busy", 32'(ifa.busy), 0);
      rst_n = 1;
      tick();

      // Single word, latency t+1 / t+2 / t+3 / t+4
      ifa.word_in = 16'hA55A; ifa.word_wr_en = 1;
      tick();
      ifa.word_wr_en = 0;
      check("sw_level_t1", 32'(ifa.fifo_level), 1);
      check("sw_valid_t1", 32'(ifa.byte_valid), 0);
      tick();
      check("sw_valid_t2", 32'(ifa.byte_valid), 1);
      check("sw_msb_t2", 32'(ifa.byte_out), 32'hA5);
      check("sw_busy_t2", 32'(ifa.busy), 1);
      check("sw_level_t2", 32'(ifa.fifo_level), 0);
      tick();
      check("sw_valid_t3", 32'(ifa.byte_valid), 1);
      check("sw_lsb_t3", 32'(ifa.byte_out), 32'h5A);
      tick();
      check("sw_valid_t4", 32'(ifa.byte_valid), 0);
      check("sw_byte_t4", 32'(ifa.byte_out), 0);
      check("sw_busy_t4", 32'(ifa.busy), 0);

      // Backpressure: 5 stalled cycles in MSB, 3 in LSB
      qa.delete(); ca.delete();
      ifa.byte_ready = 0;
      ifa.word_in = 16'h1234; ifa.word_wr_en = 1;
      tick();
      ifa.word_wr_en = 0;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_msb_hold", {23'd0, ifa.byte_valid, ifa.byte_out}, 32'h112);
         tick();
      end
      ifa.byte_ready = 1;
      tick();
      ifa.byte_ready = 0;
      for (int k = 0; k < 3; k++) begin
         check("bp_lsb_hold", {23'd0, ifa.byte_valid, ifa.byte_out}, 32'h134);
         tick();
      end
      ifa.byte_ready = 1;
      tick();
      check("bp_valid_end", 32'(ifa.byte_valid), 0);
      check("bp_xfer_cnt", 32'(qa.size()), 2);
      check("bp_xfer0", 32'(qa[0]), 32'h12);
      check("bp_xfer1", 32'(qa[1]), 32'h34);

      // Fill and overflow; clear on the dropping edge must lose to set
      ifa.byte_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         ifa.word_in = 16'(i); ifa.word_wr_en = 1; ifa.clear_overflow = (i == 6);
         tick();
         if (i == 5) begin
            check("fill_full_5", 32'(ifa.fifo_full), 1);
            check("fill_ovf_5", 32'(ifa.overflow), 0);
         end
      end
      ifa.word_wr_en = 0; ifa.clear_overflow = 0;
      check("fill_ovf_setwins", 32'(ifa.overflow), 1);
      check("fill_level", 32'(ifa.fifo_level), 4);
      check("fill_full", 32'(ifa.fifo_full), 1);
      check("fill_head_msb", {23'd0, ifa.byte_valid, ifa.byte_out}, 32'h100);
      qa.delete(); ca.delete();
      ifa.byte_ready = 1;
      repeat (20) tick();
      check("drain_cnt", 32'(qa.size()), 10);
      for (int k = 0; k < 10; k++)
         check("drain_byte", 32'(qa[k]), (k % 2 == 0) ? 32'd0 : 32'(k / 2 + 1));
      check("drain_spacing", 32'(ca[2] - ca[1]), 2);
      check("drain_level", 32'(ifa.fifo_level), 0);
      check("drain_full", 32'(ifa.fifo_full), 0);
      check("drain_ovf_sticky", 32'(ifa.overflow), 1);

      // Reset while in LSB with two words buffered
      ifa.byte_ready = 0;
      ifa.word_wr_en = 1;
      ifa.word_in = 16'hAAAA; tick();
      ifa.word_in = 16'hBBBB; tick();
      ifa.word_in = 16'hCCCC; tick();
      ifa.word_wr_en = 0;
      ifa.byte_ready = 1;
      tick();
      ifa.byte_ready = 0;
      check("mid_lsb_byte", 32'(ifa.byte_out), 32'hAA);
      check("mid_level", 32'(ifa.fifo_level), 2);
      check("mid_busy", 32'(ifa.busy), 1);
      #2 rst_n = 0;
      #1;
      check("arst_valid", 32'(ifa.byte_valid), 0);
      check("arst_byte", 32'(ifa.byte_out), 0);
      check("arst_level", 32'(ifa.fifo_level), 0);
      check("arst_busy", 32'(ifa.busy), 0);
      check("arst_ovf", 32'(ifa.overflow), 0);
      repeat (2) tick();
      rst_n = 1;
      qa.delete(); ca.delete();
      ifa.byte_ready = 1;
      repeat (10) tick();
      check("post_rst_bytes", 32'(qa.size()), 0);
      check("post_rst_level", 32'(ifa.fifo_level), 0);

      // clear_overflow alone clears the sticky flag
      ifa.byte_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         ifa.word_in = 16'(i); ifa.word_wr_en = 1;
         tick();
      end
      ifa.word_wr_en = 0;
      check("ovf_again", 32'(ifa.overflow), 1);
      ifa.clear_overflow = 1;
      tick();
      ifa.clear_overflow = 0;
      check("ovf_cleared", 32'(ifa.overflow), 0);
      ifa.byte_ready = 1;
      repeat (20) tick();
      check("ovf_drain_level", 32'(ifa.fifo_level), 0);

      // Loopback into a 2-byte assembler model
      qa.delete(); ca.delete();
      exp_w[0] = 16'hBEEF; exp_w[1] = 16'h0000; exp_w[2] = 16'hFFFF;
      for (int w = 0; w < 3; w++) begin
         ifa.word_in = exp_w[w]; ifa.word_wr_en = 1;
         tick();
      end
      ifa.word_wr_en = 0;
      repeat (15) tick();
      check("lb_cnt", 32'(qa.size()), 6);
      for (int w = 0; w < 3; w++)
         check("lb_word", {16'd0, qa[2*w], qa[2*w+1]}, 32'(exp_w[w]));

      // Gap instance: 3 gap cycles plus one IDLE between words
      ifb.word_wr_en = 1;
      ifb.word_in = 16'h1111; tick();
      ifb.word_in = 16'h2222; tick();
      ifb.word_wr_en = 0;
      repeat (20) tick();
      check("gap_cnt", 32'(qb.size()), 4);
      check("gap_b0", 32'(qb[0]), 32'h11);
      check("gap_b2", 32'(qb[2]), 32'h22);
      check("gap_msb_lsb", 32'(cb[1] - cb[0]), 1);
      check("gap_spacing", 32'(cb[2] - cb[1]), 5);
      check("gap_idle_end", 32'(ifb.busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
